// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW onto a word-indexed memory.
// Sub-word stores use read-modify-write; rejected requests answer with an error and never touch memory.
module load_store_unit #(
   parameter int unsigned DEPTH = 256
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state_q, state_d;
   logic        ready_q, ready_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic [15:0] wdata_q, wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      logic bad_f3;
      logic misaligned;
      logic out_of_range;
      if (we) bad_f3 = (f3 > 3'b010);
      else    bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                     ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      out_of_range = ({2'b00, addr[31:2]} >= DEPTH);
      return bad_f3 || misaligned || out_of_range;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] off);
      logic        [7:0]  b;
      logic        [15:0] h;
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      logic signed [31:0] ext;
      b  = word[{off, 3'b000} +: 8];
      h  = off[1] ? word[31:16] : word[15:0];
      sb = b;
      sh = h;
      case (f3)
         3'b000:  ext = 32'(sb);
         3'b001:  ext = 32'(sh);
         3'b100:  ext = {24'd0, b};
         3'b101:  ext = {16'd0, h};
         default: ext = word;
      endcase
      return ext;
   endfunction

   // Only SB/SH reach the merge; SW writes the request data directly.
   function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [15:0] wd,
                                               input logic [1:0] size, input logic [1:0] off);
      logic [31:0] m;
      m = old;
      if (size == 2'b00) m[{off, 3'b000} +: 8]       = wd[7:0];
      else               m[{off[1], 4'b0000} +: 16] = wd;
      return m;
   endfunction

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      wdata_d      = wdata_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'd0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;

      case (state_q)
         IDLE: begin
            if (req_valid_i && ready_q) begin
               we_d       = req_we_i;
               funct3_d   = req_funct3_i;
               off_d      = req_addr_i[1:0];
               wdata_d    = req_wdata_i[15:0];
               mem_addr_d = {2'b00, req_addr_i[31:2]};
               if (req_error(req_we_i, req_funct3_i, req_addr_i)) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_we_i && (req_funct3_i[1:0] == 2'b10)) begin
                  state_d     = WRITE;
                  mem_we_d    = 1'b1;
                  mem_wdata_d = req_wdata_i;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (we_q) begin
               state_d     = WRITE;
               mem_we_d    = 1'b1;
               mem_wdata_d = store_merge(mem_rdata_i, wdata_q, funct3_q[1:0], off_q);
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_extend(mem_rdata_i, funct3_q, off_q);
            end
         end
         WRITE: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
   end

   // Every output is a flop, so reset clears mem_we_o without waiting for a clock.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         ready_q      <= 1'b0;
         we_q         <= 1'b0;
         funct3_q     <= 3'd0;
         off_q        <= 2'd0;
         wdata_q      <= 16'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         ready_q      <= ready_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign req_ready_o  = ready_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_err_o   = resp_err_q;
   assign resp_rdata_o = resp_rdata_q;
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a behavioural 256-word data memory.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   load_store_unit #(.DEPTH(256)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
      .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          nwe;
      logic [31:0] waddr;
      logic [31:0] wdata;
      int          acc;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mem [256];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          we_seen = 0;

   assign mem_rdata = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cyc == 0) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hAFAFAFAF;
      end else if (mem_we && (mem_addr < 32'd256)) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         we_seen = 0;
      end else begin
         if (mem_we) begin
            we_seen++;
            if (sbq.size() == 0) check_eq("write_without_request", sbq.size(), 1);
            else begin
               check_eq("write_addr", mem_addr, sbq[0].waddr);
               check_eq("write_data", mem_wdata, sbq[0].wdata);
            end
         end
         if (resp_valid) begin
            if (sbq.size() == 0) check_eq("resp_without_request", sbq.size(), 1);
            else begin
               e = sbq.pop_front();
               check_eq("resp_rdata", resp_rdata, e.rdata);
               check_eq("resp_err", {31'd0, resp_err}, {31'd0, e.err});
               check_eq("latency", cyc - e.acc + 1, e.lat);
               check_eq("write_count", we_seen, e.nwe);
               we_seen = 0;
            end
         end
      end
   end

   // Called at a falling edge; returns at the falling edge just after the accepting rising edge.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_nwe, input logic [31:0] exp_wdata,
                         input bit hold);
      exp_t e;
      int   n = 0;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check_eq("accept_timeout", n, 0);
         req_valid = 1'b0;
         return;
      end
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.lat   = exp_lat;
      e.nwe   = exp_nwe;
      e.waddr = {2'b00, addr[31:2]};
      e.wdata = exp_wdata;
      e.acc   = cyc + 1;
      sbq.push_back(e);
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sbq.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check_eq("drain_timeout", sbq.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check_eq("rst_resp_err", {31'd0, resp_err}, 32'd0);
      check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check_eq("rst_rdata", resp_rdata, 32'd0);
      check_eq("rst_mem_addr", mem_addr, 32'd0);
      check_eq("rst_mem_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("ready_after_reset", {31'd0, req_ready}, 32'd1);

      do_req(1, 3'b010, 32'h10, 32'h12345678, 32'h0, 0, 2, 1, 32'h12345678, 0);
      wait_idle();
      check_eq("mem4_after_sw", mem[4], 32'h12345678);
      do_req(0, 3'b010, 32'h10, 32'h0, 32'h12345678, 0, 2, 0, 32'h0, 0);
      wait_idle();

      do_req(1, 3'b000, 32'h11, 32'h000000CD, 32'h0, 0, 3, 1, 32'h1234CD78, 0);
      wait_idle();
      do_req(0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFCD, 0, 2, 0, 32'h0, 0);
      do_req(0, 3'b100, 32'h11, 32'h0, 32'h000000CD, 0, 2, 0, 32'h0, 0);
      wait_idle();

      do_req(1, 3'b001, 32'h12, 32'h00008001, 32'h0, 0, 3, 1, 32'h8001CD78, 0);
      do_req(0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 0, 2, 0, 32'h0, 0);
      do_req(0, 3'b101, 32'h12, 32'h0, 32'h00008001, 0, 2, 0, 32'h0, 0);
      do_req(0, 3'b010, 32'h10, 32'h0, 32'h8001CD78, 0, 2, 0, 32'h0, 0);
      do_req(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0, 2, 0, 32'h0, 0);
      do_req(0, 3'b100, 32'h10, 32'h0, 32'h00000078, 0, 2, 0, 32'h0, 0);
      do_req(0, 3'b010, 32'h3FC, 32'h0, 32'hAFAFAFAF, 0, 2, 0, 32'h0, 0);
      wait_idle();

      do_req(0, 3'b010, 32'h13, 32'h0, 32'h0, 1, 1, 0, 32'h0, 0);
      do_req(1, 3'b001, 32'h11, 32'hFFFF, 32'h0, 1, 1, 0, 32'h0, 0);
      do_req(0, 3'b010, 32'h400, 32'h0, 32'h0, 1, 1, 0, 32'h0, 0);
      do_req(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, 0, 32'h0, 0);
      do_req(1, 3'b011, 32'h10, 32'h11111111, 32'h0, 1, 1, 0, 32'h0, 0);
      wait_idle();
      check_eq("mem4_after_errors", mem[4], 32'h8001CD78);

      do_req(1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'hDEADBEEF, 1);
      do_req(0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 0, 2, 0, 32'h0, 1);
      do_req(1, 3'b010, 32'h44, 32'h0BADF00D, 32'h0, 0, 2, 1, 32'h0BADF00D, 1);
      do_req(0, 3'b010, 32'h44, 32'h0, 32'h0BADF00D, 0, 2, 0, 32'h0, 0);
      wait_idle();

      do_req(1, 3'b000, 32'h20, 32'h00000055, 32'h0, 0, 3, 1, 32'hAFAFAF55, 0);
      @(negedge clk);
      check_eq("write_state_reached", {31'd0, mem_we}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("we_drops_with_reset", {31'd0, mem_we}, 32'd0);
      check_eq("resp_drops_with_reset", {31'd0, resp_valid}, 32'd0);
      sbq.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("ready_after_midreset", {31'd0, req_ready}, 32'd1);
      check_eq("mem8_untouched", mem[8], 32'hAFAFAFAF);
      do_req(0, 3'b010, 32'h20, 32'h0, 32'hAFAFAFAF, 0, 2, 0, 32'h0, 0);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached with %0d entries pending", sbq.size());
      $fatal(1, "watchdog");
   end

endmodule
